// File: rtl/csa_accumulator_if.sv
// Operand stream in, resolved result stream out, for the carry-save accumulator.
// The master drives operands and out_ready; the slave is the accumulator.
interface csa_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] result;
  logic                 overflow;
  logic [7:0]           op_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, result, overflow, op_count
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, result, overflow, op_count
  );
endinterface

// File: rtl/csa_accumulator.sv
// Streaming accumulator: operands fold into a redundant (sum, carry) pair, then a
// chunked ripple adder resolves the pair to binary over NCH cycles per frame.
module csa_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int CHUNK     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_accumulator_if.slave  bus
);
  localparam int NCH = ACC_WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = CHUNK + 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t               state, state_nx;
  logic [ACC_WIDTH-1:0] sum_r, carry_r, result_r, x, maj;
  logic [KW-1:0]        k;
  logic                 rc, ovf_r;
  logic [7:0]           cnt_r;
  logic [CW-1:0]        csum;
  logic                 acc_fire, out_fire, last_chunk;

  assign x          = ACC_WIDTH'(bus.in_data);
  assign maj        = (sum_r & carry_r) | (sum_r & x) | (carry_r & x);
  assign acc_fire   = bus.in_valid && (state == ACCUM);
  assign out_fire   = bus.out_ready && (state == OUTPUT);
  assign last_chunk = (k == KW'(NCH - 1));
  assign csum       = {1'b0, sum_r[k*CHUNK +: CHUNK]} + {1'b0, carry_r[k*CHUNK +: CHUNK]} + CW'(rc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (acc_fire && bus.in_last) state_nx = RESOLVE;
      RESOLVE: if (last_chunk)              state_nx = OUTPUT;
      OUTPUT:  if (bus.out_ready)           state_nx = ACCUM;
      default:                              state_nx = ACCUM;
    endcase
  end

  // Handshake outputs decode state only, so no input reaches an output combinationally.
  always_comb begin
    bus.in_ready  = (state == ACCUM);
    bus.out_valid = (state == OUTPUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r    <= '0;
      carry_r  <= '0;
      result_r <= '0;
      k        <= '0;
      rc       <= 1'b0;
      ovf_r    <= 1'b0;
      cnt_r    <= '0;
    end else begin
      case (state)
        ACCUM: if (acc_fire) begin
          sum_r   <= sum_r ^ carry_r ^ x;
          carry_r <= maj << 1;
          // The carry shifted out of the top is a dropped 2^ACC_WIDTH weight.
          if (maj[ACC_WIDTH-1]) ovf_r <= 1'b1;
          if (cnt_r != 8'hFF)   cnt_r <= cnt_r + 8'd1;
          if (bus.in_last) begin
            k  <= '0;
            rc <= 1'b0;
          end
        end
        RESOLVE: begin
          result_r[k*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
          rc <= csum[CHUNK];
          if (last_chunk) begin
            k <= '0;
            if (csum[CHUNK]) ovf_r <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        OUTPUT: if (out_fire) begin
          sum_r   <= '0;
          carry_r <= '0;
          cnt_r   <= '0;
          ovf_r   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_r;
  assign bus.overflow = ovf_r;
  assign bus.op_count = cnt_r;
endmodule

// File: tb/tb_csa_accumulator.sv
// Randomized and directed frames against a plain-arithmetic frame-sum model;
// expected results queue up at issue and a negedge monitor checks the output stream.
module tb_csa_accumulator;
  localparam int WIDTH = 4;
  localparam int ACC_W = 8;
  localparam int CHUNK = 4;
  localparam int NCH   = ACC_W / CHUNK;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic             ovf;
    logic [7:0]       cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W)) ifc ();

  csa_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  exp_t             exp_q[$];
  logic [WIDTH-1:0] fq[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs must match the head of the queue for every cycle they are
  // presented, and the entry retires on the cycle the handshake completes.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("result",   ifc.result,   exp_q[0].res);
        chk("overflow", ifc.overflow, exp_q[0].ovf);
        chk("op_count", ifc.op_count, exp_q[0].cnt);
        if (ifc.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last);
    int t = 0;
    while (!ifc.in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("accept_ready", ifc.in_ready, 1);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = last;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  // gap < 0 picks 0..3 idle cycles per beat at random; hold = cycles out_ready stays low.
  task automatic run_frame(input int gap, input int hold, input bit pulse);
    int unsigned tot = 0;
    int n = fq.size();
    int t;
    exp_t e;
    ifc.out_ready = (hold == 0);
    foreach (fq[i]) begin
      if (i > 0) repeat ((gap < 0) ? $urandom_range(3, 0) : gap) begin
        @(posedge clk); #1;
      end
      tot += fq[i];
      send_beat(fq[i], i == n - 1);
    end
    e.res = ACC_W'(tot);
    e.ovf = (tot >= (1 << ACC_W));
    e.cnt = (n > 255) ? 8'd255 : 8'(n);
    exp_q.push_back(e);
    chk("ready_in_resolve", ifc.in_ready,  0);
    chk("valid_in_resolve", ifc.out_valid, 0);
    repeat (NCH - 1) begin
      @(posedge clk); #1;
      chk("valid_early", ifc.out_valid, 0);
    end
    @(posedge clk); #1;
    chk("valid_latency", ifc.out_valid, 1);
    for (int c = 0; c < hold; c++) begin
      if (pulse) begin
        ifc.in_valid = ~ifc.in_valid;
        ifc.in_data  = 4'd9;
        ifc.in_last  = 1'b1;
      end
      @(posedge clk); #1;
      chk("ready_in_output", ifc.in_ready,  0);
      chk("valid_held",      ifc.out_valid, 1);
    end
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    t = 0;
    while (ifc.out_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("valid_drop", ifc.out_valid, 0);
    chk("ready_after_out", ifc.in_ready, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  ifc.in_ready,  1);
    chk({tag, "_out_valid"}, ifc.out_valid, 0);
    chk({tag, "_result"},    ifc.result,    0);
    chk({tag, "_overflow"},  ifc.overflow,  0);
    chk({tag, "_op_count"},  ifc.op_count,  0);
  endtask

  initial begin
    int t;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    #3;
    chk_reset_vals("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    fq = '{4'd15};                     run_frame(0, 0, 0);
    fq = '{4'd12, 4'd5, 4'd12};        run_frame(0, 0, 0);
    fq.delete(); repeat (18) fq.push_back(4'd15);
    run_frame(0, 0, 0);
    fq = '{4'd1, 4'd2, 4'd3};          run_frame(1, 0, 0);
    fq = '{4'd6, 4'd4};                run_frame(0, 5, 1);
    fq = '{4'd1, 4'd1};                run_frame(0, 0, 0);

    // Reset while resolving: the pending frame is dropped, not reported.
    send_beat(4'd7, 1'b0);
    send_beat(4'd7, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fq = '{4'd3};                      run_frame(0, 0, 0);

    fq.delete(); repeat (300) fq.push_back(4'd15);
    run_frame(0, 0, 0);

    for (int f = 0; f < 14; f++) begin
      int len = $urandom_range(40, 1);
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back(WIDTH'($urandom_range(15, 0)));
      run_frame(-1, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
